// File: rtl/pe_ec_tiled_pkg.sv
// Shared types and helpers for the channel-tiled conv/pool/binarize PE.
package pe_ec_tiled_pkg;

  // Processing-element control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_POOL  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Clamp a derived width to at least one bit.
  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // Row-major pixel index inside a window of the given width.
  function automatic int pix_idx(input int r, input int c, input int width);
    return r * width + c;
  endfunction

endpackage

// File: rtl/pe_ec_tiled_popcnt.sv
// Combinational XNOR-popcount of one kernel slice against the weight slice.
module bin_popcnt_slice #(
  parameter int N    = 576,
  parameter int PC_W = 10
) (
  input  logic [N-1:0]    i_slice,
  input  logic [N-1:0]    i_weight,
  output logic [PC_W-1:0] o_count
);

  logic [N-1:0] w_match;

  assign w_match = ~(i_slice ^ i_weight);

  // Sum the matching bits.
  always_comb begin
    o_count = '0;
    for (int b = 0; b < N; b++) begin
      o_count = o_count + PC_W'(w_match[b]);
    end
  end

endmodule

// File: rtl/pe_ec_tiled.sv
// Channel-tiled binary conv + pool + binarize processing element.
// Input stream: a beat transfers when in_valid & in_ready; output stream: a
// result transfers when out_valid & out_ready. Valid is never withdrawn by
// the producer side inside this block, and outputs stay stable while
// out_valid is high and out_ready is low.
module pe_ec_tiled
  import pe_ec_tiled_pkg::*;
#(
  parameter int D             = 512,
  parameter int DP            = 64,
  parameter int FH            = 3,
  parameter int FW            = 3,
  parameter int POOL_H        = 2,
  parameter int POOL_W        = 2,
  parameter int STRIDE_H      = 1,
  parameter int STRIDE_W      = 1,
  parameter int NORMREF_WIDTH = 14,
  localparam int IWH    = (POOL_H - 1) * STRIDE_H + FH,
  localparam int IWW    = (POOL_W - 1) * STRIDE_W + FW,
  localparam int PIDX_W = max1($clog2(POOL_H * POOL_W))
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DP*IWH*IWW-1:0]    data_in,
  input  logic [DP*FH*FW-1:0]      weight_in,
  input  logic [NORMREF_WIDTH-1:0] norm_ref,
  input  logic                     s,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     data_out,
  output logic [PIDX_W-1:0]        pindex,
  output logic [1:0]               dbg_state
);

  localparam int N_K     = POOL_H * POOL_W;
  localparam int N_BEATS = D / DP;
  localparam int KW      = FH * FW * DP;
  localparam int IN_W    = DP * IWH * IWW;
  localparam int ACC_MAX = FH * FW * D;
  localparam int ACC_W   = $clog2(ACC_MAX + 1);
  localparam int PC_W    = $clog2(KW + 1);
  localparam int TW      = ACC_W + NORMREF_WIDTH + 2;
  localparam int BC_W    = max1($clog2(N_BEATS));

  state_t                     r_state;
  logic [BC_W-1:0]            r_beat_cnt;
  logic [ACC_W-1:0]           r_acc [N_K];
  logic [NORMREF_WIDTH-1:0]   r_norm_ref;
  logic                       r_s;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic                       r_data_out;
  logic [PIDX_W-1:0]          r_pindex;
  logic                       r_sel_res;
  logic [PIDX_W-1:0]          r_sel_k;

  logic [KW-1:0]              w_slice [N_K];
  logic [PC_W-1:0]            w_pc [N_K];
  logic [ACC_W-1:0]           w_sel_acc;
  logic [PIDX_W-1:0]          w_sel_k;
  logic [TW-1:0]              w_nr_ext;
  logic signed [TW-1:0]       w_t;
  logic signed [TW-1:0]       w_two_sel;
  logic                       w_res;

  // Gather the FHxFW pixel slice each conv position sees in the window.
  always_comb begin
    for (int k = 0; k < N_K; k++) begin
      w_slice[k] = '0;
      for (int m = 0; m < FH; m++) begin
        for (int n = 0; n < FW; n++) begin
          w_slice[k][KW-1-(m*FW+n)*DP -: DP] =
            data_in[IN_W-1-pix_idx((k/POOL_W)*STRIDE_H+m, (k%POOL_W)*STRIDE_W+n, IWW)*DP -: DP];
        end
      end
    end
  end

  for (genvar gk = 0; gk < N_K; gk++) begin : g_pc
    bin_popcnt_slice #(.N(KW), .PC_W(PC_W)) u_pc (
      .i_slice  (w_slice[gk]),
      .i_weight (weight_in),
      .o_count  (w_pc[gk])
    );
  end

  // Pick max (s=0) or min (s=1); strict compare keeps the lowest k on ties.
  always_comb begin
    w_sel_acc = r_acc[0];
    w_sel_k   = '0;
    for (int k = 1; k < N_K; k++) begin
      if (r_s ? (r_acc[k] < w_sel_acc) : (r_acc[k] > w_sel_acc)) begin
        w_sel_acc = r_acc[k];
        w_sel_k   = PIDX_W'(k);
      end
    end
  end

  // Exact threshold: compare 2*sel against FH*FW*D + norm_ref in signed math.
  assign w_nr_ext  = {{(TW-NORMREF_WIDTH){r_norm_ref[NORMREF_WIDTH-1]}}, r_norm_ref};
  assign w_t       = $signed(w_nr_ext) + $signed(TW'(ACC_MAX));
  assign w_two_sel = $signed({{(TW-ACC_W-1){1'b0}}, w_sel_acc, 1'b0});
  assign w_res     = r_s ? (w_two_sel < w_t) : (w_two_sel > w_t);

  // Control FSM with accumulators and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_beat_cnt  <= '0;
      for (int k = 0; k < N_K; k++) r_acc[k] <= '0;
      r_norm_ref  <= '0;
      r_s         <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_data_out  <= 1'b0;
      r_pindex    <= '0;
      r_sel_res   <= 1'b0;
      r_sel_k     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < N_K; k++) r_acc[k] <= ACC_W'(w_pc[k]);
            r_norm_ref <= norm_ref;
            r_s        <= s;
            if (N_BEATS == 1) begin
              r_state    <= ST_POOL;
              r_in_ready <= 1'b0;
            end else begin
              r_state    <= ST_ACCUM;
              r_beat_cnt <= BC_W'(1);
            end
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            for (int k = 0; k < N_K; k++) r_acc[k] <= r_acc[k] + ACC_W'(w_pc[k]);
            if (r_beat_cnt == BC_W'(N_BEATS - 1)) begin
              r_state    <= ST_POOL;
              r_in_ready <= 1'b0;
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + BC_W'(1);
            end
          end
        end
        ST_POOL: begin
          r_sel_res <= w_res;
          r_sel_k   <= w_sel_k;
          r_state   <= ST_OUT;
        end
        ST_OUT: begin
          // First OUT cycle presents the result; later cycles wait for the sink.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_data_out  <= r_sel_res;
            r_pindex    <= r_sel_k;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign pindex    = r_pindex;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pe_ec_tiled.sv
// Directed bench for pe_ec_tiled with D=4, DP=2, 3x3 filter, 2x2 pool.
module tb_pe_ec_tiled;

  localparam int D      = 4;
  localparam int DP     = 2;
  localparam int IN_W   = 32;
  localparam int W_W    = 18;
  localparam int NR_W   = 14;
  localparam int PIDX_W = 2;

  // Window with ones at (0,0),(3,0),(3,2),(3,3) and a single bit at (2,3).
  // Per beat vs all-ones weights: k0=2, k1=1, k2=4, k3=5; two beats double it.
  localparam logic [IN_W-1:0] DATA_MIX  = 32'hC00001CF;
  localparam logic [IN_W-1:0] DATA_ONES = 32'hFFFFFFFF;
  localparam logic [IN_W-1:0] DATA_ZERO = 32'h0;
  localparam logic [W_W-1:0]  W_ONES    = 18'h3FFFF;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic [IN_W-1:0] data_in;
  logic [W_W-1:0]  weight_in;
  logic [NR_W-1:0] norm_ref;
  logic s;
  logic out_valid;
  logic out_ready;
  logic data_out;
  logic [PIDX_W-1:0] pindex;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pe_ec_tiled #(
    .D(D), .DP(DP), .FH(3), .FW(3), .POOL_H(2), .POOL_W(2),
    .STRIDE_H(1), .STRIDE_W(1), .NORMREF_WIDTH(NR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .weight_in (weight_in),
    .norm_ref  (norm_ref),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .pindex    (pindex),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [IN_W-1:0] d, input logic [W_W-1:0] w,
                      input logic [NR_W-1:0] nr, input logic sv);
    in_valid  = 1'b1;
    data_in   = d;
    weight_in = w;
    norm_ref  = nr;
    s         = sv;
    chk("in_ready_beat", 32'(in_ready), 32'd1);
    tick();
    in_valid  = 1'b0;
  endtask

  // Two-beat transaction; beat 1 carries altered norm_ref/s that must be ignored.
  task automatic run_txn(input string tag, input logic [IN_W-1:0] d, input logic [W_W-1:0] w,
                         input logic [NR_W-1:0] nr, input logic sv,
                         input logic exp_do, input logic [PIDX_W-1:0] exp_k,
                         input int gap, input logic hold);
    beat(d, w, nr, sv);
    repeat (gap) tick();
    beat(d, w, nr + 14'd100, ~sv);
    chk({tag, "_lat_t0"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_lat_t1"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_lat_t2"}, 32'(out_valid), 32'd1);
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    chk({tag, "_data_out"}, 32'(data_out), 32'(exp_do));
    chk({tag, "_pindex"}, 32'(pindex), 32'(exp_k));
    if (!hold) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    weight_in = '0;
    norm_ref  = '0;
    s         = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_pindex", 32'(pindex), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // out_ready while idle has no effect.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_out_ready", 32'(out_valid), 32'd0);

    // 1: all match, acc=36 everywhere, 72>36, tie -> k0.
    run_txn("t1", DATA_ONES, W_ONES, 14'd0, 1'b0, 1'b1, 2'd0, 0, 1'b0);
    // 2: no match, acc=0, 0>36 false.
    run_txn("t2", DATA_ZERO, W_ONES, 14'd0, 1'b0, 1'b0, 2'd0, 0, 1'b0);
    // 3: norm_ref=-40 -> T=-4, 0>-4.
    run_txn("t3", DATA_ZERO, W_ONES, -14'sd40, 1'b0, 1'b1, 2'd0, 0, 1'b0);
    // 3b: min-pool, 0<36.
    run_txn("t3b", DATA_ZERO, W_ONES, 14'd0, 1'b1, 1'b1, 2'd0, 0, 1'b0);
    // 4: scores 4,2,8,10; max k3 -> 20>36 false.
    run_txn("t4max", DATA_MIX, W_ONES, 14'd0, 1'b0, 1'b0, 2'd3, 0, 1'b0);
    // 4: min k1 -> 4<36.
    run_txn("t4min", DATA_MIX, W_ONES, 14'd0, 1'b1, 1'b1, 2'd1, 0, 1'b0);
    // 4: max with norm_ref=-20 -> T=16, 20>16.
    run_txn("t4nr", DATA_MIX, W_ONES, -14'sd20, 1'b0, 1'b1, 2'd3, 0, 1'b0);

    // 5: backpressure; offered beats must be refused.
    run_txn("t5", DATA_MIX, W_ONES, -14'sd20, 1'b0, 1'b1, 2'd3, 0, 1'b1);
    in_valid  = 1'b1;
    data_in   = DATA_ZERO;
    weight_in = W_ONES;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_hold_valid", 32'(out_valid), 32'd1);
      chk("t5_hold_data", 32'(data_out), 32'd1);
      chk("t5_hold_pindex", 32'(pindex), 32'd3);
      chk("t5_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    // 5b: release.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5b_valid", 32'(out_valid), 32'd0);
    chk("t5b_in_ready", 32'(in_ready), 32'd1);
    chk("t5b_state", 32'(dbg_state), 32'd0);
    run_txn("t5c", DATA_ONES, W_ONES, 14'd0, 1'b0, 1'b1, 2'd0, 0, 1'b0);

    // 6: reset after beat 0, then a fresh transaction.
    beat(DATA_ONES, W_ONES, 14'd0, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_state", 32'(dbg_state), 32'd0);
    chk("t6_rst_data_out", 32'(data_out), 32'd0);
    chk("t6_rst_pindex", 32'(pindex), 32'd0);
    rst_n = 1'b1;
    tick();
    run_txn("t6", DATA_MIX, W_ONES, -14'sd20, 1'b0, 1'b1, 2'd3, 0, 1'b0);

    // 6b: gaps between beats.
    run_txn("t6b", DATA_MIX, W_ONES, 14'd0, 1'b1, 1'b1, 2'd1, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
